// File: rtl/vizinho_proximo_escalavel_if.sv
// Pixel stream bundle for the nearest-neighbour upscaler: input stream plus output stream.
// NN_FRAME_MARKERS_EN adds start-of-frame and end-of-line markers on the output stream.
interface vizinho_proximo_escalavel_if #(
  parameter int PIXEL_W = 8
);
  logic [PIXEL_W-1:0] pixel_in;
  logic               pixel_in_valid;
  logic               pixel_in_ready;
  logic [PIXEL_W-1:0] pixel_out;
  logic               pixel_out_valid;
  logic               pixel_out_ready;
`ifdef NN_FRAME_MARKERS_EN
  logic               pixel_out_sof;
  logic               pixel_out_eol;
`endif

  modport master (
    output pixel_in, pixel_in_valid, pixel_out_ready,
`ifdef NN_FRAME_MARKERS_EN
    input  pixel_out_sof, pixel_out_eol,
`endif
    input  pixel_in_ready, pixel_out, pixel_out_valid
  );

  modport slave (
    input  pixel_in, pixel_in_valid, pixel_out_ready,
`ifdef NN_FRAME_MARKERS_EN
    output pixel_out_sof, pixel_out_eol,
`endif
    output pixel_in_ready, pixel_out, pixel_out_valid
  );
endinterface

// File: rtl/vizinho_proximo_escalavel.sv
// Nearest-neighbour upscaler: buffers one input row, replays each pixel S times and each row S times.
// Optional NN_FRAME_MARKERS_EN adds registered sof/eol markers alongside pixel_out.
module vizinho_proximo_escalavel #(
  parameter int PIXEL_W        = 8,
  parameter int LARGURA_MAXIMA = 640,
  parameter int ESCALA_MAXIMA  = 4,
  parameter int DIM_W          = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [2:0]                     escala_in,
  input  logic [DIM_W-1:0]               largura_in,
  input  logic [DIM_W-1:0]               altura_in,
  vizinho_proximo_escalavel_if.slave     fluxo,
  output logic                           busy,
  output logic                           processing_done,
  output logic                           config_error
);
  typedef enum logic [1:0] {S_IDLE, S_RECEBENDO, S_ENVIANDO, S_FINALIZANDO} estado_t;

  localparam logic [DIM_W-1:0] LARG_MAX = DIM_W'(LARGURA_MAXIMA);
  localparam logic [2:0]       ESC_MAX  = 3'(ESCALA_MAXIMA);
  localparam logic [DIM_W-1:0] UM       = DIM_W'(1);

  estado_t estado, proximo;

  logic [PIXEL_W-1:0] linha [LARGURA_MAXIMA];
  logic [DIM_W-1:0]   w, h, x_in, y_in, x_rd;
  logic [2:0]         s, rep_x, rep_y;
  logic [PIXEL_W-1:0] out_pix;
  logic               out_vld;

  logic cfg_ok, aceita, cfg_ruim, in_rdy, escreve, carrega, entrega;
  logic fim_pixel, fim_linha, fim_copia, ultima_linha, fim_recepcao;

  assign cfg_ok = (largura_in != '0) && (altura_in != '0) &&
                  (escala_in != 3'd0) && (escala_in <= ESC_MAX);

  assign fim_pixel    = (rep_x == s - 3'd1);
  assign fim_linha    = (x_rd == w - UM);
  assign fim_copia    = (rep_y == s - 3'd1);
  assign ultima_linha = (y_in == h - UM);
  assign fim_recepcao = (x_in == w - UM);

  always_ff @(posedge clk) begin
    if (reset) estado <= S_IDLE;
    else       estado <= proximo;
  end

  always_comb begin
    proximo  = estado;
    aceita   = 1'b0;
    cfg_ruim = 1'b0;
    in_rdy   = 1'b0;
    escreve  = 1'b0;
    carrega  = 1'b0;
    entrega  = 1'b0;
    case (estado)
      S_IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            aceita  = 1'b1;
            proximo = S_RECEBENDO;
          end else begin
            cfg_ruim = 1'b1;
          end
        end
      end
      S_RECEBENDO: begin
        in_rdy  = 1'b1;
        escreve = fluxo.pixel_in_valid;
        if (escreve && fim_recepcao) proximo = S_ENVIANDO;
      end
      S_ENVIANDO: begin
        carrega = !out_vld || fluxo.pixel_out_ready;
        // Last load of the last row copy frees the buffer for the next row.
        if (carrega && fim_pixel && fim_linha && fim_copia)
          proximo = ultima_linha ? S_FINALIZANDO : S_RECEBENDO;
      end
      S_FINALIZANDO: begin
        if (fluxo.pixel_out_ready) begin
          entrega = 1'b1;
          proximo = S_IDLE;
        end
      end
      default: proximo = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (escreve) linha[x_in] <= fluxo.pixel_in;
  end

`ifdef NN_FRAME_MARKERS_EN
  logic out_sof, out_eol;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      w <= '0; h <= '0; s <= '0;
      x_in <= '0; y_in <= '0; x_rd <= '0; rep_x <= '0; rep_y <= '0;
      out_pix <= '0; out_vld <= 1'b0;
      processing_done <= 1'b0; config_error <= 1'b0;
`ifdef NN_FRAME_MARKERS_EN
      out_sof <= 1'b0; out_eol <= 1'b0;
`endif
    end else begin
      processing_done <= entrega;
      config_error    <= cfg_ruim;
      if (aceita) begin
        w <= (largura_in > LARG_MAX) ? LARG_MAX : largura_in;
        h <= altura_in;
        s <= escala_in;
        x_in <= '0; y_in <= '0; x_rd <= '0; rep_x <= '0; rep_y <= '0;
      end
      if (escreve) x_in <= fim_recepcao ? '0 : x_in + UM;
      if (carrega) begin
        out_pix <= linha[x_rd];
        out_vld <= 1'b1;
`ifdef NN_FRAME_MARKERS_EN
        out_sof <= (y_in == '0) && (rep_y == 3'd0) && (x_rd == '0) && (rep_x == 3'd0);
        out_eol <= fim_pixel && fim_linha;
`endif
        // Replication by counting copies rather than dividing output coordinates.
        if (!fim_pixel) begin
          rep_x <= rep_x + 3'd1;
        end else begin
          rep_x <= 3'd0;
          if (!fim_linha) begin
            x_rd <= x_rd + UM;
          end else begin
            x_rd <= '0;
            if (!fim_copia) begin
              rep_y <= rep_y + 3'd1;
            end else begin
              rep_y <= 3'd0;
              if (!ultima_linha) y_in <= y_in + UM;
            end
          end
        end
      end else if (out_vld && fluxo.pixel_out_ready) begin
        out_vld <= 1'b0;
      end
    end
  end

  assign fluxo.pixel_in_ready  = in_rdy;
  assign fluxo.pixel_out       = out_pix;
  assign fluxo.pixel_out_valid = out_vld;
`ifdef NN_FRAME_MARKERS_EN
  assign fluxo.pixel_out_sof   = out_sof;
  assign fluxo.pixel_out_eol   = out_eol;
`endif
  assign busy = (estado != S_IDLE);

endmodule

// File: tb/tb_vizinho_proximo_escalavel.sv
// Bench for the nearest-neighbour upscaler: frame-level reference model, per-beat scoreboard,
// literal pins for the model, config errors, width clamp and mid-frame reset.
module tb_vizinho_proximo_escalavel;
  localparam int PW = 8;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [2:0]    escala_in;
  logic [DW-1:0] largura_in, altura_in;
  logic          busy, processing_done, config_error;

  always #5 clk = ~clk;

  vizinho_proximo_escalavel_if #(.PIXEL_W(PW)) bus ();

  vizinho_proximo_escalavel #(
    .PIXEL_W(PW), .LARGURA_MAXIMA(640), .ESCALA_MAXIMA(4), .DIM_W(DW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .escala_in       (escala_in),
    .largura_in      (largura_in),
    .altura_in       (altura_in),
    .fluxo           (bus),
    .busy            (busy),
    .processing_done (processing_done),
    .config_error    (config_error)
  );

  typedef struct {
    logic [PW-1:0] pix;
    logic          sof;
    logic          eol;
  } beat_t;

  int            errors = 0;
  int            checks = 0;
  beat_t         exp_q[$];
  logic [PW-1:0] got_q[$];
  logic          got_sof[$];
  logic          got_eol[$];
  logic [PW-1:0] in_pix[$];
  int            idx = 0;
  bit            feed_en = 0;
  bit            rand_gaps = 0;
  bit            in_fire = 0;
  int            cyc = 0;
  int            done_cnt = 0;
  int            last_xfer_cyc = -10;
  bit            held_vld = 0;
  logic [PW-1:0] held_pix;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Input/ready driver: changes only just after the active edge.
  always @(posedge clk) begin
    #1;
    if (in_fire) idx++;
    if (feed_en && idx < in_pix.size()) begin
      bus.pixel_in_valid = rand_gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.pixel_in       = in_pix[idx];
    end else begin
      bus.pixel_in_valid = 1'b0;
    end
    bus.pixel_out_ready = rand_gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Compare process: every output transfer is checked against the model queue.
  always @(negedge clk) begin
    beat_t e;
    in_fire = bus.pixel_in_valid && bus.pixel_in_ready;
    if (reset) begin
      held_vld = 0;
    end else begin
      if (processing_done) begin
        done_cnt++;
        check("done_after_last_beat", cyc - last_xfer_cyc, 1);
        check("done_with_beats_left", exp_q.size(), 0);
      end
      if (held_vld && !bus.pixel_out_valid) check("valid_dropped_in_stall", 0, 1);
      if (bus.pixel_out_valid) begin
        if (held_vld) check("stall_hold", bus.pixel_out, held_pix);
        if (bus.pixel_out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_beat: got pixel %0d, expected no beat (t=%0t)", bus.pixel_out, $time);
          end else begin
            e = exp_q.pop_front();
            if (bus.pixel_out !== e.pix) begin
              errors++;
              $display("FAIL pixel: got %0d, expected %0d (t=%0t)", bus.pixel_out, e.pix, $time);
            end
`ifdef NN_FRAME_MARKERS_EN
            check("sof", bus.pixel_out_sof, e.sof);
            check("eol", bus.pixel_out_eol, e.eol);
`endif
          end
          got_q.push_back(bus.pixel_out);
`ifdef NN_FRAME_MARKERS_EN
          got_sof.push_back(bus.pixel_out_sof);
          got_eol.push_back(bus.pixel_out_eol);
`endif
          last_xfer_cyc = cyc;
          held_vld = 0;
        end else begin
          held_vld = 1;
          held_pix = bus.pixel_out;
        end
      end else begin
        held_vld = 0;
      end
    end
  end

  // Reference: output row r copies input row r/S, output column c copies input column c/S.
  task automatic build_model(input int w, input int h, input int s);
    int    weff;
    beat_t b;
    weff = (w > 640) ? 640 : w;
    exp_q.delete();
    got_q.delete();
    got_sof.delete();
    got_eol.delete();
    for (int r = 0; r < h * s; r++)
      for (int c = 0; c < weff * s; c++) begin
        b.pix = in_pix[(r / s) * weff + (c / s)];
        b.sof = (r == 0 && c == 0);
        b.eol = (c == weff * s - 1);
        exp_q.push_back(b);
      end
  endtask

  task automatic start_frame(input int w, input int h, input int s, input bit gaps);
    @(negedge clk);
    idx        = 0;
    rand_gaps  = gaps;
    feed_en    = 1;
    start      = 1'b1;
    escala_in  = 3'(s);
    largura_in = DW'(w);
    altura_in  = DW'(h);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input int s, input bit gaps);
    int d0, n, weff;
    weff = (w > 640) ? 640 : w;
    build_model(w, h, s);
    n  = exp_q.size();
    d0 = done_cnt;
    start_frame(w, h, s, gaps);
    for (int i = 0; i < n * 4 + weff * h * 4 + 200 && done_cnt == d0; i++) @(negedge clk);
    check("frame_done_within_budget", done_cnt - d0, 1);
    repeat (4) @(negedge clk);
    feed_en = 0;
    check("done_exactly_once", done_cnt - d0, 1);
    check("beats_left_in_model", exp_q.size(), 0);
    check("inputs_consumed", idx, weff * h);
    check("idle_after_frame", busy, 0);
  endtask

  task automatic cfg_error(input int w, input int h, input int s);
    @(negedge clk);
    start      = 1'b1;
    escala_in  = 3'(s);
    largura_in = DW'(w);
    altura_in  = DW'(h);
    @(negedge clk);
    start = 1'b0;
    check("config_error_pulse", config_error, 1);
    check("busy_on_bad_cfg", busy, 0);
    @(negedge clk);
    check("config_error_one_cycle", config_error, 0);
    check("busy_stays_low", busy, 0);
  endtask

  initial begin
    logic [PW-1:0] lit1 [16] = '{10, 10, 20, 20, 10, 10, 20, 20, 30, 30, 40, 40, 30, 30, 40, 40};
    int d0;

    reset      = 1'b1;
    start      = 1'b0;
    escala_in  = '0;
    largura_in = '0;
    altura_in  = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {bus.pixel_out, bus.pixel_out_valid, bus.pixel_in_ready, busy, processing_done, config_error}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 2x2 frame, S=2, literal expectation.
    in_pix = '{8'd10, 8'd20, 8'd30, 8'd40};
    run_frame(2, 2, 2, 0);
    check("lit_2x2_len", got_q.size(), 16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) check("lit_2x2_beat", got_q[i], lit1[i]);

    // 3x1 frame, S=3: 1x3,2x3,3x3 repeated three rows.
    in_pix = '{8'd1, 8'd2, 8'd3};
    run_frame(3, 1, 3, 0);
    check("lit_3x1_len", got_q.size(), 27);
    for (int i = 0; i < 27 && i < got_q.size(); i++) check("lit_3x1_beat", got_q[i], (i % 9) / 3 + 1);

    // S=1 pass-through under random stalls on both sides.
    in_pix.delete();
    for (int i = 0; i < 8; i++) in_pix.push_back(PW'($urandom));
    run_frame(4, 2, 1, 1);
    check("s1_len", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check("s1_passthrough", got_q[i], in_pix[i]);

    cfg_error(4, 2, 0);
    cfg_error(4, 2, 5);
    cfg_error(0, 2, 2);
    cfg_error(4, 0, 2);

    // Maximum scale with random stalls.
    in_pix.delete();
    for (int i = 0; i < 15; i++) in_pix.push_back(PW'($urandom));
    run_frame(5, 3, 4, 1);

    // Reset in the middle of a frame, then a clean frame.
    in_pix.delete();
    for (int i = 0; i < 8; i++) in_pix.push_back(PW'($urandom));
    build_model(4, 2, 2);
    d0 = done_cnt;
    start_frame(4, 2, 2, 0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_midframe_outputs",
          {bus.pixel_out, bus.pixel_out_valid, bus.pixel_in_ready, busy, processing_done, config_error}, 0);
    feed_en = 0;
    exp_q.delete();
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("no_done_after_abort", done_cnt - d0, 0);
    in_pix.delete();
    for (int i = 0; i < 4; i++) in_pix.push_back(PW'($urandom));
    run_frame(2, 2, 2, 1);

    // Width above the row buffer is clamped; the excess is left unconsumed.
    in_pix.delete();
    for (int i = 0; i < 700; i++) in_pix.push_back(PW'($urandom));
    run_frame(700, 1, 1, 0);
    check("clamp_len", got_q.size(), 640);

`ifdef NN_FRAME_MARKERS_EN
    in_pix = '{8'd5, 8'd6};
    run_frame(2, 1, 2, 0);
    check("markers_len", got_sof.size(), 8);
    for (int i = 0; i < 8 && i < got_sof.size(); i++) begin
      check("lit_sof", got_sof[i], (i == 0) ? 1 : 0);
      check("lit_eol", got_eol[i], (i == 3 || i == 7) ? 1 : 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
